// File: rtl/map_irq_cyc.sv
// ---------------------------------------------------------------------------
// map_irq_cyc -- CPU-cycle IRQ mapper core for discrete-logic boards.
//
// One 8-bit bank register supplies the switchable PRG bank ($8000-$BFFF, with
// $C000-$FFFF fixed to the last bank) and the CHR bank for $1000-$1FFF.
// An M2-cycle counter raises IRQ in one of two modes:
//   MODE=0 legacy free-run : irq = counter MSB, any $C000-$FFFF write clears it
//   MODE=1 reload/one-shot : programmable down-counter with a sticky flag
// All state moves on the falling edge of m2. Save-state access freezes the
// normal logic and exposes every register through ss_addr/ss_we/ss_rdat.
// Save-state write data is taken from cpu_dat.
//
// Ports
//   m2        in   clock, state updates on negedge
//   map_rst_n in   asynchronous reset, active-low
//   cpu_addr  in   CPU A14..A0
//   cpu_dat   in   CPU write data (also save-state write data)
//   cpu_rw    in   1=read, 0=write
//   cpu_ce    in   active-low $8000-$FFFF select
//   ppu_a12   in   PPU A12
//   ss_act    in   save-state mode, normal writes ignored while high
//   ss_we     in   save-state write strobe
//   ss_addr   in   save-state register index
//   ss_rdat   out  save-state readback (combinational)
//   prg_hi    out  PRG address bits above A13
//   chr_hi    out  CHR address bits above A11
//   irq       out  IRQ request, active-high
// ---------------------------------------------------------------------------
module map_irq_cyc #(
    parameter int CTR_W      = 11,
    parameter int PRG_BANK_W = 2,
    parameter int CHR_BANK_W = 4
) (
    input  logic                  m2,
    input  logic                  map_rst_n,
    input  logic [14:0]           cpu_addr,
    input  logic [7:0]            cpu_dat,
    input  logic                  cpu_rw,
    input  logic                  cpu_ce,
    input  logic                  ppu_a12,
    input  logic                  ss_act,
    input  logic                  ss_we,
    input  logic [7:0]            ss_addr,
    output logic [7:0]            ss_rdat,
    output logic [PRG_BANK_W-1:0] prg_hi,
    output logic [CHR_BANK_W-1:0] chr_hi,
    output logic                  irq
);

    localparam logic [CTR_W-1:0] CTR_ONE = 1;

    logic [7:0]       bank_reg,   bank_next;
    logic [2:0]       ctrl_reg,   ctrl_next;
    logic [CTR_W-1:0] reload_reg, reload_next;
    logic [CTR_W-1:0] ctr_reg,    ctr_next;
    logic             flag_reg,   flag_next;

    // Only the region select and the reload byte select are decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[12:1];

    // Zero-extended views used for byte-wide save-state and reload access.
    logic [15:0] ctr_wide, reload_wide;
    assign ctr_wide    = 16'(ctr_reg);
    assign reload_wide = 16'(reload_reg);

    logic ctrl_en, ctrl_mode, ctrl_auto;
    assign ctrl_en   = ctrl_reg[0];
    assign ctrl_mode = ctrl_reg[1];
    assign ctrl_auto = ctrl_reg[2];

    logic wr, wr_bank, wr_ctrl, wr_reload, ack;
    assign wr        = !cpu_rw && !cpu_ce && !ss_act;
    assign wr_bank   = wr && (cpu_addr[14:13] == 2'b00);
    assign wr_ctrl   = wr && (cpu_addr[14:13] == 2'b01);
    assign wr_reload = wr && (cpu_addr[14:13] == 2'b10);
    // Legacy mode treats the whole $C000-$FFFF range as acknowledge.
    assign ack       = wr && cpu_addr[14] && (cpu_addr[13] || !ctrl_mode);

    // A ctrl write takes effect on the enable in the same edge, so writing
    // EN=0 suppresses a coincident expiry.
    logic en_eff;
    assign en_eff = wr_ctrl ? cpu_dat[0] : ctrl_en;

    logic [15:0] tmp_wide;

    always_comb begin
        bank_next   = bank_reg;
        ctrl_next   = ctrl_reg;
        reload_next = reload_reg;
        ctr_next    = ctr_reg;
        flag_next   = flag_reg;
        tmp_wide    = 16'h0000;

        if (ss_act) begin
            if (ss_we) begin
                case (ss_addr)
                    8'd0: bank_next = cpu_dat;
                    8'd1: ctrl_next = cpu_dat[2:0];
                    8'd2: begin
                        tmp_wide       = ctr_wide;
                        tmp_wide[7:0]  = cpu_dat;
                        ctr_next       = tmp_wide[CTR_W-1:0];
                    end
                    8'd3: begin
                        tmp_wide       = ctr_wide;
                        tmp_wide[15:8] = cpu_dat;
                        ctr_next       = tmp_wide[CTR_W-1:0];
                    end
                    8'd4: begin
                        tmp_wide       = reload_wide;
                        tmp_wide[7:0]  = cpu_dat;
                        reload_next    = tmp_wide[CTR_W-1:0];
                    end
                    8'd5: begin
                        tmp_wide       = reload_wide;
                        tmp_wide[15:8] = cpu_dat;
                        reload_next    = tmp_wide[CTR_W-1:0];
                    end
                    8'd6: flag_next = cpu_dat[0];
                    default: ;
                endcase
            end
        end else begin
            // Counter step in the current mode.
            if (!ctrl_mode) begin
                ctr_next = ack ? '0 : ctr_reg + CTR_ONE;
            end else if (ack) begin
                flag_next = 1'b0;
                ctr_next  = reload_reg;
            end else if (en_eff) begin
                if (ctr_reg != '0) begin
                    ctr_next = ctr_reg - CTR_ONE;
                end else begin
                    flag_next = 1'b1;
                    ctr_next  = ctrl_auto ? reload_reg : '0;
                end
            end

            if (wr_bank)
                bank_next = cpu_dat;

            // The new reload value is only used at the next load event.
            if (wr_reload) begin
                tmp_wide = reload_wide;
                if (cpu_addr[0])
                    tmp_wide[15:8] = cpu_dat;
                else
                    tmp_wide[7:0]  = cpu_dat;
                reload_next = tmp_wide[CTR_W-1:0];
            end

            if (wr_ctrl) begin
                ctrl_next = cpu_dat[2:0];
                if (cpu_dat[1] != ctrl_mode) begin
                    ctr_next  = '0;
                    flag_next = 1'b0;
                end else if (!cpu_dat[0]) begin
                    flag_next = 1'b0;
                end
            end
        end
    end

    always_ff @(negedge m2 or negedge map_rst_n) begin
        if (!map_rst_n) begin
            bank_reg   <= '0;
            ctrl_reg   <= '0;
            reload_reg <= '0;
            ctr_reg    <= '0;
            flag_reg   <= 1'b0;
        end else begin
            bank_reg   <= bank_next;
            ctrl_reg   <= ctrl_next;
            reload_reg <= reload_next;
            ctr_reg    <= ctr_next;
            flag_reg   <= flag_next;
        end
    end

    assign prg_hi = cpu_addr[14] ? '1 : bank_reg[7 -: PRG_BANK_W];
    assign chr_hi = ppu_a12 ? bank_reg[CHR_BANK_W-1:0] : '0;
    assign irq    = ctrl_mode ? flag_reg : ctr_reg[CTR_W-1];

    always_comb begin
        case (ss_addr)
            8'd0:    ss_rdat = bank_reg;
            8'd1:    ss_rdat = {5'b0, ctrl_reg};
            8'd2:    ss_rdat = ctr_wide[7:0];
            8'd3:    ss_rdat = ctr_wide[15:8];
            8'd4:    ss_rdat = reload_wide[7:0];
            8'd5:    ss_rdat = reload_wide[15:8];
            8'd6:    ss_rdat = {7'b0, flag_reg};
            default: ss_rdat = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_map_irq_cyc.sv
`timescale 1ns/10ps
module tb_map_irq_cyc;

    logic        m2;
    logic        map_rst_n;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_dat;
    logic        cpu_rw;
    logic        cpu_ce;
    logic        ppu_a12;
    logic        ss_act;
    logic        ss_we;
    logic [7:0]  ss_addr;
    logic [7:0]  ss_rdat;
    logic [1:0]  prg_hi;
    logic [3:0]  chr_hi;
    logic        irq;

    int errors = 0;
    int checks = 0;

    map_irq_cyc #(.CTR_W(11), .PRG_BANK_W(2), .CHR_BANK_W(4)) dut (
        .m2        (m2),
        .map_rst_n (map_rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_dat   (cpu_dat),
        .cpu_rw    (cpu_rw),
        .cpu_ce    (cpu_ce),
        .ppu_a12   (ppu_a12),
        .ss_act    (ss_act),
        .ss_we     (ss_we),
        .ss_addr   (ss_addr),
        .ss_rdat   (ss_rdat),
        .prg_hi    (prg_hi),
        .chr_hi    (chr_hi),
        .irq       (irq)
    );

    // Rising edges are idle for the DUT; stimulus changes and sampling
    // happen there, state changes on the falling edge.
    initial m2 = 1'b1;
    always #5 m2 = ~m2;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s val=%h", tag, got);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge m2);
    endtask

    // Call just after a rising edge; the write is taken on the next falling edge.
    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a[14:0];
        cpu_dat  = d;
        cpu_rw   = 1'b0;
        cpu_ce   = 1'b0;
        @(posedge m2);
        cpu_rw   = 1'b1;
        cpu_ce   = 1'b1;
        $display("wr   addr=%h data=%h", a, d);
    endtask

    task automatic ss_wr(input logic [7:0] idx, input logic [7:0] d);
        ss_addr = idx;
        cpu_dat = d;
        ss_we   = 1'b1;
        @(posedge m2);
        ss_we   = 1'b0;
        $display("ssw  idx=%0d data=%h", idx, d);
    endtask

    task automatic check_ss(input string tag, input logic [7:0] idx, input logic [7:0] exp);
        ss_addr = idx;
        #0.1;
        check(tag, {8'h00, ss_rdat}, {8'h00, exp});
    endtask

    initial begin
        map_rst_n = 1'b1;
        cpu_addr  = 15'h0000;
        cpu_dat   = 8'h00;
        cpu_rw    = 1'b1;
        cpu_ce    = 1'b1;
        ppu_a12   = 1'b0;
        ss_act    = 1'b0;
        ss_we     = 1'b0;
        ss_addr   = 8'd0;
        #1 map_rst_n = 1'b0;
        #1;
        // Reset state
        check("rst_irq", {15'b0, irq}, 16'h0000);
        check("rst_prg_a14_0", {14'b0, prg_hi}, 16'h0000);
        cpu_addr = 15'h4000;
        ppu_a12  = 1'b1;
        #0.1;
        check("rst_prg_a14_1", {14'b0, prg_hi}, 16'h0003);
        check("rst_chr", {12'b0, chr_hi}, 16'h0000);
        check_ss("rst_ctr_lo", 8'd2, 8'h00);
        ppu_a12  = 1'b0;
        cpu_addr = 15'h0000;
        @(posedge m2);
        map_rst_n = 1'b1;

        // 1. Legacy free-run: MSB of 11-bit counter rises at cycle 1024
        idle(1023);
        check("leg_irq_1023", {15'b0, irq}, 16'h0000);
        idle(1);
        check("leg_irq_1024", {15'b0, irq}, 16'h0001);
        cpu_wr(16'hC000, 8'h00);
        check("leg_ack_irq", {15'b0, irq}, 16'h0000);
        check_ss("leg_ack_ctr", 8'd2, 8'h00);

        // 2. Banking
        cpu_wr(16'h8000, 8'hC5);
        cpu_addr = 15'h0000;
        ppu_a12  = 1'b1;
        #0.1;
        check("bank_prg_c5_a0", {14'b0, prg_hi}, 16'h0003);
        check("bank_chr_a12_1", {12'b0, chr_hi}, 16'h0005);
        cpu_addr = 15'h4000;
        ppu_a12  = 1'b0;
        #0.1;
        check("bank_prg_c5_a1", {14'b0, prg_hi}, 16'h0003);
        check("bank_chr_a12_0", {12'b0, chr_hi}, 16'h0000);
        cpu_wr(16'h8000, 8'h45);
        cpu_addr = 15'h0000;
        #0.1;
        check("bank_prg_45_a0", {14'b0, prg_hi}, 16'h0001);

        // 3. Reload one-shot
        cpu_wr(16'hC000, 8'd10);
        cpu_wr(16'hC001, 8'd0);
        cpu_wr(16'hA000, 8'h03);
        cpu_wr(16'hE000, 8'h00);
        check_ss("os_ack_ctr", 8'd2, 8'd10);
        idle(10);
        check("os_irq_before", {15'b0, irq}, 16'h0000);
        check_ss("os_ctr_zero", 8'd2, 8'h00);
        idle(1);
        check("os_irq_expiry", {15'b0, irq}, 16'h0001);
        idle(50);
        check("os_irq_hold", {15'b0, irq}, 16'h0001);
        check_ss("os_ctr_hold", 8'd2, 8'h00);
        cpu_wr(16'hE000, 8'h00);
        check("os_irq_ack", {15'b0, irq}, 16'h0000);

        // 4. Auto-reload, period reload+1
        cpu_wr(16'hC000, 8'd3);
        cpu_wr(16'hA000, 8'h07);
        cpu_wr(16'hE000, 8'h00);
        check_ss("ar_ack_ctr", 8'd2, 8'd3);
        idle(3);
        check("ar_irq_3", {15'b0, irq}, 16'h0000);
        idle(1);
        check("ar_irq_4", {15'b0, irq}, 16'h0001);
        check_ss("ar_reloaded", 8'd2, 8'd3);
        idle(3);
        cpu_wr(16'hE000, 8'h00);
        check("ar_ack_vs_exp_irq", {15'b0, irq}, 16'h0000);
        check_ss("ar_ack_vs_exp_ctr", 8'd2, 8'd3);

        // 5. Save state
        ss_act = 1'b1;
        ss_wr(8'd2, 8'h34);
        ss_wr(8'd3, 8'h05);
        ss_wr(8'd6, 8'h01);
        check_ss("ss_ctr_lo", 8'd2, 8'h34);
        check_ss("ss_ctr_hi", 8'd3, 8'h05);
        check_ss("ss_flag", 8'd6, 8'h01);
        cpu_wr(16'h8000, 8'h00);
        idle(4);
        check_ss("ss_frozen_ctr", 8'd2, 8'h34);
        check_ss("ss_bank_ignored", 8'd0, 8'h45);
        check_ss("ss_ctrl", 8'd1, 8'h07);
        check_ss("ss_bad_idx", 8'd9, 8'hFF);
        check_ss("ss_reload_hi", 8'd5, 8'h00);
        ss_act = 1'b0;
        idle(1);
        check_ss("ss_resume_lo", 8'd2, 8'h33);
        check_ss("ss_resume_hi", 8'd3, 8'h05);
        check("ss_resume_irq", {15'b0, irq}, 16'h0001);

        // 6. Async reset mid-count
        idle(3);
        #1 map_rst_n = 1'b0;
        #0.1;
        check("ar_rst_irq", {15'b0, irq}, 16'h0000);
        check_ss("ar_rst_ctr", 8'd2, 8'h00);
        check_ss("ar_rst_flag", 8'd6, 8'h00);
        check_ss("ar_rst_ctrl", 8'd1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
